ysyx_24120013_core_ctrl: RTL

- Multi-cycle sequencer for the single-issue core. Fetches each instruction over a req/ready/rvalid memory handshake and holds it in an instruction register that drives the decoder.
- Steps decode, execute and writeback, and gates the register-file write enable and the PC update.
- Halts on ebreak. Traps on an illegal command or a fetch timeout.
- Sits between instruction memory and the IDU/EXU/RF datapath.

---
 rtl/ysyx_24120013_core_ctrl_pkg.sv | 22 ++
 rtl/ysyx_24120013_core_ctrl_if.sv | 27 ++
 rtl/ysyx_24120013_core_ctrl_fetch_timer.sv | 38 +++
 rtl/ysyx_24120013_core_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ysyx_24120013_core_ctrl_pkg.sv
// Shared definitions for the core sequencer: one-hot states, IDU command codes
// and fixed instruction encodings.
package ysyx_24120013_pkg;

   typedef enum logic [6:0] {
      S_FETCH  = 7'b000_0001,
      S_WAIT   = 7'b000_0010,
      S_DECODE = 7'b000_0100,
      S_EXEC   = 7'b000_1000,
      S_WB     = 7'b001_0000,
      S_HALT   = 7'b010_0000,
      S_TRAP   = 7'b100_0000
   } state_e;

   localparam logic [1:0]  CMD_NONE         = 2'b00;
   localparam logic [1:0]  CMD_OPIMM        = 2'b01;

   localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24120013_core_ctrl_if.sv
// Instruction-memory request/response channel between the core sequencer and
// its fetch port.
interface ysyx_24120013_core_ctrl_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/ysyx_24120013_core_ctrl_fetch_timer.sv
// Loadable down-counter guarding the wait for fetch data; expired_o is high
// while the count sits at zero.
module ysyx_24120013_fetch_timer #(
   parameter int unsigned      WIDTH    = 4,
   parameter logic [WIDTH-1:0] LOAD_VAL = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ysyx_24120013_core_ctrl.sv
// Multi-cycle sequencer: fetch over the imem handshake, then decode, execute
// and writeback, gating the register-file write and the PC update.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_FETCH  | request at pc, wait for imem_ready
//   S_WAIT   | wait for imem_rvalid, timer bounds the wait
//   S_DECODE | inst stable; ebreak -> halt, no command -> trap
//   S_EXEC   | datapath computes, no side effects
//   S_WB     | rf_wen (OP-IMM only), pc <= dnpc, retire_cnt++
//   S_HALT   | ebreak reached, terminal until reset
//   S_TRAP   | illegal command or fetch timeout, terminal until reset
module ysyx_24120013_core_ctrl
   import ysyx_24120013_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          TIMEOUT   = 16,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   ysyx_24120013_core_ctrl_if.master    imem,
   output logic [31:0]                  inst,
   input  logic [1:0]                   IDU_command,
   input  logic [31:0]                  dnpc,
   output logic [31:0]                  pc,
   output logic                         rf_wen,
   output logic [CNT_WIDTH-1:0]         retire_cnt,
   output logic                         halt,
   output logic                         trap
);

   localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            inst_q, inst_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   tmr_clr, tmr_load, tmr_en, tmr_expired;

   ysyx_24120013_fetch_timer #(
      .WIDTH    (TMR_W),
      .LOAD_VAL (TMR_W'(TIMEOUT - 1))
   ) u_fetch_timer (
      .clk       (clk),
      .rst_n     (rst),
      .clr_i     (tmr_clr),
      .load_i    (tmr_load),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         inst_q  <= INST_NOP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      cnt_d    = cnt_q;
      tmr_clr  = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem.imem_ready) begin
               state_d  = S_WAIT;
               tmr_load = 1'b1;
            end
         end
         S_WAIT: begin
            // rvalid in the last allowed cycle still completes the fetch
            if (imem.imem_rvalid) begin
               inst_d  = imem.imem_rdata;
               state_d = S_DECODE;
               tmr_clr = 1'b1;
            end else if (tmr_expired) begin
               state_d = S_TRAP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         S_DECODE: begin
            if (inst_q == INST_EBREAK) begin
               state_d = S_HALT;
            end else if (IDU_command == CMD_NONE) begin
               state_d = S_TRAP;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_WB;
         end
         S_WB: begin
            pc_d    = dnpc;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase
   end

   // reset state is S_FETCH, so the request is also gated by reset itself
   assign imem.imem_req  = (state_q == S_FETCH) && rst;
   assign imem.imem_addr = pc_q;

   assign inst       = inst_q;
   assign pc         = pc_q;
   assign retire_cnt = cnt_q;
   assign rf_wen     = (state_q == S_WB) && (IDU_command == CMD_OPIMM);
   assign halt       = (state_q == S_HALT);
   assign trap       = (state_q == S_TRAP);

endmodule
